// File: rtl/spr_bank_pkg.sv
// spr_bank_pkg
//   Shared definitions for the special-purpose register bank: architectural
//   SPR indices, reset level, FSM state encoding and an index-width helper.
//   No ports.
package spr_bank_pkg;

    localparam int   SPR_IDX_HI = 0;
    localparam int   SPR_IDX_LO = 1;
    localparam logic RST_ENABLE = 1'b0;

    typedef enum logic {
        SPR_IDLE = 1'b0,
        SPR_BUSY = 1'b1
    } spr_state_t;

    // A one-entry bank still needs a 1-bit index port.
    function automatic int spr_idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/spr_bank_if.sv
// spr_bank_if
//   Pipeline-side bundle of the SPR bank: EX read port, MEM/WB forwarding and
//   commit lanes, multi-cycle mul/div handshake and status outputs.
//   Modports:
//     master - pipeline side (drives requests, observes read data/status)
//     slave  - spr_bank side
interface spr_bank_if #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 2,
    parameter int IDX_W    = 1
);
    logic                         rd_en_i;
    logic [IDX_W-1:0]             rd_idx_i;
    logic [DATA_W-1:0]            rd_data_o;
    logic                         stall_o;
    logic [NUM_REGS-1:0]          mem_we_i;
    logic [NUM_REGS*DATA_W-1:0]   mem_data_i;
    logic [NUM_REGS-1:0]          wb_we_i;
    logic [NUM_REGS*DATA_W-1:0]   wb_data_i;
    logic                         md_issue_i;
    logic [NUM_REGS-1:0]          md_dst_i;
    logic                         md_done_i;
    logic [NUM_REGS*DATA_W-1:0]   md_data_i;
    logic                         flush_i;
    logic                         busy_o;
    logic                         err_o;

    modport master (
        output rd_en_i, rd_idx_i, mem_we_i, mem_data_i, wb_we_i, wb_data_i,
               md_issue_i, md_dst_i, md_done_i, md_data_i, flush_i,
        input  rd_data_o, stall_o, busy_o, err_o
    );

    modport slave (
        input  rd_en_i, rd_idx_i, mem_we_i, mem_data_i, wb_we_i, wb_data_i,
               md_issue_i, md_dst_i, md_done_i, md_data_i, flush_i,
        output rd_data_o, stall_o, busy_o, err_o
    );

endinterface

// File: rtl/spr_fwd_mux.sv
// spr_fwd_mux
//   Combinational forwarding mux for one SPR read lane.
//   Priority: MEM > WB > multi-cycle result > stored value.
//   Ports:
//     sel_valid  in   read index maps to an existing SPR (else output 0)
//     mem_hit    in   MEM stage writes this SPR      mem_data in
//     wb_hit     in   WB stage writes this SPR       wb_data  in
//     md_hit     in   mul/div result for this SPR    md_data  in
//     stored     in   architectural SPR value
//     rd_data    out  forwarded read data
module spr_fwd_mux #(
    parameter int DATA_W = 32
) (
    input  logic              sel_valid,
    input  logic              mem_hit,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              wb_hit,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              md_hit,
    input  logic [DATA_W-1:0] md_data,
    input  logic [DATA_W-1:0] stored,
    output logic [DATA_W-1:0] rd_data
);

    always_comb begin
        rd_data = '0;
        if (sel_valid) begin
            if (mem_hit)     rd_data = mem_data;
            else if (wb_hit) rd_data = wb_data;
            else if (md_hit) rd_data = md_data;
            else             rd_data = stored;
        end
    end

endmodule

// File: rtl/spr_bank.sv
// spr_bank
//   Special-purpose register bank (HI/LO, ...) read in EX, written from WB.
//   Forwards MEM/WB/mul-div results and keeps a pending-write mask for an
//   outstanding multi-cycle op so EX reads of busy SPRs stall.
//   Optional macro SPR_PERF_EN adds perf_stall_cnt_o (saturating count of
//   stall cycles).
//   Ports:
//     clk               in   clock, all state on posedge
//     rst               in   async reset, active-low
//     bus               slave modport of spr_bank_if (read port, MEM/WB lanes,
//                       mul/div handshake, flush, busy/err status)
//     perf_stall_cnt_o  out  [31:0] stall-cycle count (SPR_PERF_EN only)
//
//   state    | meaning
//   SPR_IDLE | no multi-cycle op outstanding, pend mask is zero
//   SPR_BUSY | op outstanding; pend marks SPRs still owed a result
module spr_bank
    import spr_bank_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 2,
    parameter int IDX_W    = spr_idx_w(NUM_REGS)
) (
    input  logic clk,
    input  logic rst,
    spr_bank_if.slave bus
`ifdef SPR_PERF_EN
    ,
    output logic [31:0] perf_stall_cnt_o
`endif
);

    spr_state_t          state_q, state_d;
    logic [NUM_REGS-1:0] pend_q, pend_d;
    logic                err_q, err_d;
    logic [DATA_W-1:0]   spr_q [NUM_REGS];

    logic                sel_valid;
    logic                sel_mem_hit;
    logic                sel_wb_hit;
    logic                sel_pend;
    logic [DATA_W-1:0]   sel_mem_data;
    logic [DATA_W-1:0]   sel_wb_data;
    logic [DATA_W-1:0]   sel_md_data;
    logic [DATA_W-1:0]   sel_stored;
    logic [DATA_W-1:0]   mux_data;
    logic                stall_raw;
    logic                md_commit;

    // Lane select by comparison rather than indexing, so out-of-range
    // indices simply leave sel_valid low.
    always_comb begin
        sel_valid    = 1'b0;
        sel_mem_hit  = 1'b0;
        sel_wb_hit   = 1'b0;
        sel_pend     = 1'b0;
        sel_mem_data = '0;
        sel_wb_data  = '0;
        sel_md_data  = '0;
        sel_stored   = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (bus.rd_idx_i == IDX_W'(k)) begin
                sel_valid    = 1'b1;
                sel_mem_hit  = bus.mem_we_i[k];
                sel_wb_hit   = bus.wb_we_i[k];
                sel_pend     = pend_q[k];
                sel_mem_data = bus.mem_data_i[k*DATA_W +: DATA_W];
                sel_wb_data  = bus.wb_data_i[k*DATA_W +: DATA_W];
                sel_md_data  = bus.md_data_i[k*DATA_W +: DATA_W];
                sel_stored   = spr_q[k];
            end
        end
    end

    spr_fwd_mux #(
        .DATA_W (DATA_W)
    ) u_fwd_mux (
        .sel_valid (sel_valid),
        .mem_hit   (sel_mem_hit),
        .mem_data  (sel_mem_data),
        .wb_hit    (sel_wb_hit),
        .wb_data   (sel_wb_data),
        .md_hit    (bus.md_done_i & sel_pend),
        .md_data   (sel_md_data),
        .stored    (sel_stored),
        .rd_data   (mux_data)
    );

    // A newer MEM/WB write or the arriving result resolves the hazard.
    assign stall_raw = bus.rd_en_i & sel_valid & sel_pend & ~bus.md_done_i
                     & ~sel_mem_hit & ~sel_wb_hit;

    assign bus.rd_data_o = (rst == RST_ENABLE) ? '0 : mux_data;
    assign bus.stall_o   = (rst != RST_ENABLE) & stall_raw;
    assign bus.busy_o    = (state_q == SPR_BUSY);
    assign bus.err_o     = err_q;

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        err_d   = err_q;
        case (state_q)
            SPR_IDLE: begin
                if (bus.md_issue_i && !bus.flush_i && (bus.md_dst_i != '0)) begin
                    state_d = SPR_BUSY;
                    pend_d  = bus.md_dst_i;
                end
            end
            SPR_BUSY: begin
                if (bus.md_issue_i) err_d = 1'b1;
                // WB write to a pending SPR supersedes that lane of the result.
                pend_d = pend_q & ~bus.wb_we_i;
                if (bus.md_done_i || bus.flush_i || (pend_d == '0)) begin
                    state_d = SPR_IDLE;
                    pend_d  = '0;
                end
            end
            default: begin
                state_d = SPR_IDLE;
                pend_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE) begin
            state_q <= SPR_IDLE;
            pend_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            err_q   <= err_d;
        end
    end

    assign md_commit = (state_q == SPR_BUSY) & bus.md_done_i & ~bus.flush_i;

    // WB is younger than the mul/div op, so it wins on the same SPR.
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE) begin
            for (int k = 0; k < NUM_REGS; k++) spr_q[k] <= '0;
        end else begin
            for (int k = 0; k < NUM_REGS; k++) begin
                if (bus.wb_we_i[k])
                    spr_q[k] <= bus.wb_data_i[k*DATA_W +: DATA_W];
                else if (md_commit && pend_q[k])
                    spr_q[k] <= bus.md_data_i[k*DATA_W +: DATA_W];
            end
        end
    end

`ifdef SPR_PERF_EN
    logic [31:0] perf_q;

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE)
            perf_q <= '0;
        else if (stall_raw && (perf_q != 32'hFFFF_FFFF))
            perf_q <= perf_q + 32'd1;
    end

    assign perf_stall_cnt_o = perf_q;
`endif

endmodule

// File: tb/tb_spr_bank.sv
// tb_spr_bank
//   Directed bench for spr_bank: table of read/forwarding vectors plus
//   hand-written multi-cycle sequences (stall, WAW, flush, err, reset).
module tb_spr_bank;
    import spr_bank_pkg::*;

    localparam int DW = 32;
    localparam int NR = 2;
    localparam int IW = 1;

    logic clk;
    logic rst;
`ifdef SPR_PERF_EN
    logic [31:0] perf_cnt;
`endif

    spr_bank_if #(.DATA_W(DW), .NUM_REGS(NR), .IDX_W(IW)) bus ();

    spr_bank #(.DATA_W(DW), .NUM_REGS(NR), .IDX_W(IW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
`ifdef SPR_PERF_EN
        ,
        .perf_stall_cnt_o (perf_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic drive_idle();
        bus.rd_en_i    = 1'b0;
        bus.rd_idx_i   = '0;
        bus.mem_we_i   = '0;
        bus.mem_data_i = '0;
        bus.wb_we_i    = '0;
        bus.wb_data_i  = '0;
        bus.md_issue_i = 1'b0;
        bus.md_dst_i   = '0;
        bus.md_done_i  = 1'b0;
        bus.md_data_i  = '0;
        bus.flush_i    = 1'b0;
    endtask

    typedef struct {
        logic        rd_en;
        logic [0:0]  idx;
        logic [1:0]  mem_we;
        logic [63:0] mem_data;   // {LO, HI}
        logic [1:0]  wb_we;
        logic [63:0] wb_data;    // {LO, HI}
        logic [31:0] exp_data;
        logic        exp_stall;
    } vec_t;

    vec_t vecs [11];

    initial begin
        vecs[0]  = '{1'b1, 1'b0, 2'b00, 64'h0,                     2'b00, 64'h0,                     32'h0000_0000, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 2'b01, 64'h0000_0000_AAAA_0001,   2'b01, 64'h0000_0000_0000_5555,   32'hAAAA_0001, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 2'b00, 64'h0,                     2'b01, 64'h0000_0000_0000_5555,   32'h0000_5555, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 2'b00, 64'h0,                     2'b00, 64'h0,                     32'h0000_5555, 1'b0};
        vecs[4]  = '{1'b1, 1'b1, 2'b10, 64'h1111_2222_0000_0000,   2'b00, 64'h0,                     32'h1111_2222, 1'b0};
        vecs[5]  = '{1'b1, 1'b1, 2'b00, 64'h0,                     2'b10, 64'h0000_BEEF_0000_0000,   32'h0000_BEEF, 1'b0};
        vecs[6]  = '{1'b1, 1'b1, 2'b00, 64'h0,                     2'b00, 64'h0,                     32'h0000_BEEF, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 2'b10, 64'h0000_0123_0000_0000,   2'b00, 64'h0,                     32'h0000_5555, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 2'b00, 64'h0,                     2'b11, 64'h0000_000B_0000_000A,   32'h0000_000A, 1'b0};
        vecs[9]  = '{1'b1, 1'b1, 2'b00, 64'h0,                     2'b00, 64'h0,                     32'h0000_000B, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 2'b00, 64'h0,                     2'b00, 64'h0,                     32'h0000_000B, 1'b0};

        drive_idle();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("reset busy", 32'(bus.busy_o), 32'd0);
        chk("reset err",  32'(bus.err_o),  32'd0);

        // Forwarding priority / commit table
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            drive_idle();
            bus.rd_en_i    = vecs[i].rd_en;
            bus.rd_idx_i   = vecs[i].idx;
            bus.mem_we_i   = vecs[i].mem_we;
            bus.mem_data_i = vecs[i].mem_data;
            bus.wb_we_i    = vecs[i].wb_we;
            bus.wb_data_i  = vecs[i].wb_data;
            #1;
            chk($sformatf("vec%0d data", i),  bus.rd_data_o,       vecs[i].exp_data);
            chk($sformatf("vec%0d stall", i), 32'(bus.stall_o),    32'(vecs[i].exp_stall));
        end

        // Stall on pending LO, resolved by md_done
        @(negedge clk);
        drive_idle();
        bus.md_issue_i = 1'b1;
        bus.md_dst_i   = 2'b11;
        @(negedge clk);
        drive_idle();
        #1;
        chk("stall busy", 32'(bus.busy_o), 32'd1);
        bus.rd_en_i  = 1'b1;
        bus.rd_idx_i = 1'(SPR_IDX_LO);
        for (int c = 0; c < 4; c++) begin
            #1;
            chk($sformatf("stall cyc%0d", c), 32'(bus.stall_o), 32'd1);
            @(negedge clk);
        end
        bus.md_done_i = 1'b1;
        bus.md_data_i = 64'h0000_1234_0000_5678;
        #1;
        chk("md fwd data", bus.rd_data_o, 32'h0000_1234);
        chk("md fwd stall", 32'(bus.stall_o), 32'd0);
        @(negedge clk);
        drive_idle();
        #1;
        chk("md done idle", 32'(bus.busy_o), 32'd0);
        bus.rd_idx_i = 1'(SPR_IDX_HI);
        #1;
        chk("md commit HI", bus.rd_data_o, 32'h0000_5678);
        bus.rd_idx_i = 1'(SPR_IDX_LO);
        #1;
        chk("md commit LO", bus.rd_data_o, 32'h0000_1234);

        // WAW: WB supersedes pending HI, late md_done ignored
        @(negedge clk);
        drive_idle();
        bus.md_issue_i = 1'b1;
        bus.md_dst_i   = 2'b01;
        @(negedge clk);
        drive_idle();
        bus.wb_we_i   = 2'b01;
        bus.wb_data_i = 64'h0000_0000_0000_0077;
        #1;
        chk("waw busy", 32'(bus.busy_o), 32'd1);
        @(negedge clk);
        drive_idle();
        #1;
        chk("waw idle", 32'(bus.busy_o), 32'd0);
        bus.md_done_i = 1'b1;
        bus.md_data_i = 64'h0000_0000_0000_0099;
        bus.rd_idx_i  = 1'(SPR_IDX_HI);
        #1;
        chk("waw no fwd", bus.rd_data_o, 32'h0000_0077);
        @(negedge clk);
        drive_idle();
        #1;
        chk("waw HI kept", bus.rd_data_o, 32'h0000_0077);

        // Flush with md_done same cycle: no commit
        @(negedge clk);
        drive_idle();
        bus.md_issue_i = 1'b1;
        bus.md_dst_i   = 2'b11;
        @(negedge clk);
        drive_idle();
        bus.flush_i   = 1'b1;
        bus.md_done_i = 1'b1;
        bus.md_data_i = 64'h0000_F00D_0000_DEAD;
        @(negedge clk);
        drive_idle();
        #1;
        chk("flush idle", 32'(bus.busy_o), 32'd0);
        chk("flush HI", bus.rd_data_o, 32'h0000_0077);
        bus.rd_idx_i = 1'(SPR_IDX_LO);
        #1;
        chk("flush LO", bus.rd_data_o, 32'h0000_1234);
        bus.md_issue_i = 1'b1;
        bus.md_dst_i   = 2'b11;
        bus.flush_i    = 1'b1;
        @(negedge clk);
        drive_idle();
        #1;
        chk("flush blocks issue", 32'(bus.busy_o), 32'd0);

        // Reset pulse, then err sticky and perf count
        rst = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        chk("pulse HI zero", bus.rd_data_o, 32'h0);
        @(negedge clk);
        drive_idle();
        bus.md_issue_i = 1'b1;
        bus.md_dst_i   = 2'b01;
        @(negedge clk);
        drive_idle();
        bus.rd_en_i  = 1'b1;
        bus.rd_idx_i = 1'(SPR_IDX_HI);
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("err stall%0d", c), 32'(bus.stall_o), 32'd1);
            @(negedge clk);
        end
        drive_idle();
        #1;
        chk("err before", 32'(bus.err_o), 32'd0);
        bus.md_issue_i = 1'b1;
        bus.md_dst_i   = 2'b10;
        @(negedge clk);
        drive_idle();
        #1;
        chk("err set", 32'(bus.err_o), 32'd1);
        chk("err still busy", 32'(bus.busy_o), 32'd1);
        bus.md_done_i = 1'b1;
        bus.md_data_i = 64'h0000_0000_0000_C0DE;
        @(negedge clk);
        drive_idle();
        #1;
        chk("err sticky", 32'(bus.err_o), 32'd1);
        chk("err md idle", 32'(bus.busy_o), 32'd0);
        chk("err md HI", bus.rd_data_o, 32'h0000_C0DE);
`ifdef SPR_PERF_EN
        chk("perf count", perf_cnt, 32'd3);
`endif

        // Async reset mid-BUSY, no clock edge needed
        @(negedge clk);
        drive_idle();
        bus.md_issue_i = 1'b1;
        bus.md_dst_i   = 2'b11;
        @(negedge clk);
        drive_idle();
        bus.rd_en_i  = 1'b1;
        bus.rd_idx_i = 1'(SPR_IDX_HI);
        #1;
        chk("pre-rst busy", 32'(bus.busy_o), 32'd1);
        chk("pre-rst stall", 32'(bus.stall_o), 32'd1);
        #1;
        rst = 1'b0;
        #1;
        chk("rst busy", 32'(bus.busy_o), 32'd0);
        chk("rst err", 32'(bus.err_o), 32'd0);
        chk("rst data", bus.rd_data_o, 32'h0);
        chk("rst stall", 32'(bus.stall_o), 32'd0);
`ifdef SPR_PERF_EN
        chk("rst perf", perf_cnt, 32'd0);
`endif
        rst = 1'b1;
        #1;
        chk("rst HI zero", bus.rd_data_o, 32'h0);
        chk("rst no stall", 32'(bus.stall_o), 32'd0);
        bus.rd_idx_i = 1'(SPR_IDX_LO);
        #1;
        chk("rst LO zero", bus.rd_data_o, 32'h0);

        @(negedge clk);
        drive_idle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
